// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - settle gate, 1-in-DECIM decimator and output FIFO on a valid/ready stream
module fir_decimator #(
  parameter int DW     = 8,
  parameter int DECIM  = 4,
  parameter int SETTLE = 76,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              in_sig,
  output logic [DW-1:0]              out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       overflow
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic [SW-1:0] settle_cnt;
  logic [PW-1:0] phase;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic          settled, keep, full, pop, store;

  assign settled   = (settle_cnt == SW'(SETTLE));
  assign keep      = settled && (phase == '0);
  assign full      = (fill == FW'(DEPTH));
  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a sample when the head leaves on the same edge.
  assign store     = keep && (!full || pop);
  assign rd_next   = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= in_sig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      phase      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      overflow   <= 1'b0;
      out_data   <= '0;
    end else begin
      if (!settled) settle_cnt <= settle_cnt + SW'(1);
      else          phase      <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);

      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_next;
      if (keep && full && !pop) overflow <= 1'b1;

      case ({store, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase

      // out_data is a registered copy of the head so it holds after the last pop.
      if (pop) begin
        if (fill > FW'(1)) out_data <= mem[rd_next];
        else if (store)    out_data <= in_sig;
      end else if (store && !out_valid) begin
        out_data <= in_sig;
      end
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - scoreboard bench for fir_decimator (DECIM=4/DEPTH=8 and DECIM=1/DEPTH=4)
module tb_fir_decimator;

  localparam int SETTLE = 76;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, out_ready;
  logic [7:0] in_sig;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ovf_a, ovf_b;
  logic [3:0] fill_a;
  logic [2:0] fill_b;

  always #5 clk = ~clk;

  fir_decimator #(.DW(8), .DECIM(4), .SETTLE(SETTLE), .DEPTH(8)) dut_a (
    .clk(clk), .rst(rst_a), .in_sig(in_sig), .out_data(data_a), .out_valid(valid_a),
    .out_ready(out_ready), .fill(fill_a), .overflow(ovf_a)
  );

  fir_decimator #(.DW(8), .DECIM(1), .SETTLE(SETTLE), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_sig(in_sig), .out_data(data_b), .out_valid(valid_b),
    .out_ready(out_ready), .fill(fill_b), .overflow(ovf_b)
  );

  int cur = 0;
  int active = 0;
  int n_vec = 0;
  int n_err = 0;
  int k = 0;
  int m_fill = 0, m_settle = 0, m_phase = 0, m_ovf = 0, m_decim = 4, m_depth = 8;
  logic [7:0] exp_q[$];

  logic [7:0] s_data;
  logic       s_valid, s_ovf;
  int         s_fill;

  always_comb begin
    s_data  = data_a;
    s_valid = valid_a;
    s_ovf   = ovf_a;
    s_fill  = int'(fill_a);
    if (cur == 1) begin
      s_data  = data_b;
      s_valid = valid_b;
      s_ovf   = ovf_b;
      s_fill  = int'(fill_b);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: state against the count model every cycle, data against the queue on each accepted beat.
  always @(negedge clk) begin
    if (active != 0) begin
      chk("valid", int'(s_valid), int'(m_fill > 0));
      chk("fill", s_fill, m_fill);
      chk("overflow", int'(s_ovf), m_ovf);
      if (s_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_output: got %0d expected none (t=%0t)", s_data, $time);
        end else begin
          chk("data", int'(s_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cyc(input bit r, input logic [7:0] d, input bit rdy);
    bit p_pop, p_push;
    rst_a     = (cur == 0) ? r : 1'b1;
    rst_b     = (cur == 1) ? r : 1'b1;
    in_sig    = d;
    out_ready = rdy;
    @(posedge clk);
    if (r) begin
      m_fill = 0; m_settle = 0; m_phase = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      p_pop  = (m_fill > 0) && rdy;
      p_push = 1'b0;
      if (m_settle < SETTLE) m_settle++;
      else begin
        p_push  = (m_phase == 0);
        m_phase = (m_phase == m_decim - 1) ? 0 : m_phase + 1;
      end
      if (p_push && m_fill == m_depth && !p_pop) begin
        m_ovf  = 1;
        p_push = 1'b0;
      end
      if (p_push) exp_q.push_back(d);
      m_fill = m_fill + int'(p_push) - int'(p_pop);
    end
    #1;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 8'(k), rdy);
      k++;
    end
  endtask

  task automatic do_reset(input bit rdy);
    cyc(1'b1, 8'h00, rdy);
    k = 0;
    active = 1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; in_sig = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: ramp input, first kept sample 76 right after edge 76, then every 4th
    do_reset(1'b1);
    chk("rst_data", int'(s_data), 0);
    chk("rst_valid", int'(s_valid), 0);
    chk("rst_fill", s_fill, 0);
    chk("rst_overflow", int'(s_ovf), 0);
    run(76, 1'b1);
    chk("settle_quiet", int'(s_valid), 0);
    run(1, 1'b1);
    chk("first_valid", int'(s_valid), 1);
    chk("first_data", int'(s_data), 76);
    run(3, 1'b1);
    chk("empty_valid", int'(s_valid), 0);
    chk("empty_hold_data", int'(s_data), 76);
    run(1, 1'b1);
    chk("second_data", int'(s_data), 80);
    run(20, 1'b1);

    // 2: stalled consumer fills 76..104, 108 overflows, then drain
    do_reset(1'b0);
    run(108, 1'b0);
    chk("full_fill", s_fill, 8);
    chk("full_no_ovf", int'(s_ovf), 0);
    run(1, 1'b0);
    chk("ovf_fill", s_fill, 8);
    chk("ovf_set", int'(s_ovf), 1);
    chk("ovf_head", int'(s_data), 76);
    run(1, 1'b1);
    chk("drain_head", int'(s_data), 80);
    chk("drain_fill", s_fill, 7);
    run(40, 1'b1);
    chk("ovf_sticky", int'(s_ovf), 1);

    // 3: full FIFO, pop and push on the same edge
    do_reset(1'b0);
    run(108, 1'b0);
    run(1, 1'b1);
    chk("pp_fill", s_fill, 8);
    chk("pp_no_ovf", int'(s_ovf), 0);
    chk("pp_head", int'(s_data), 80);
    run(40, 1'b1);

    // 4: reset with 5 stored samples, settle restarts
    do_reset(1'b0);
    run(93, 1'b0);
    chk("mid_fill", s_fill, 5);
    do_reset(1'b1);
    chk("mid_rst_valid", int'(s_valid), 0);
    chk("mid_rst_fill", s_fill, 0);
    run(76, 1'b1);
    chk("resettle_quiet", int'(s_valid), 0);
    run(1, 1'b1);
    chk("resettle_first", int'(s_data), 76);
    run(4, 1'b1);
    chk("resettle_second", int'(s_data), 80);

    // 5: DECIM=1, DEPTH=4, random data and random back-pressure
    active = 0;
    cur = 1;
    m_decim = 1;
    m_depth = 4;
    do_reset(1'b0);
    chk("b_rst_fill", s_fill, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 8'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'($urandom), 1'b1);

    active = 0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
